sd_blk_server: RTL and testbench



---
 rtl/sd_blk_pkg.sv | 24 ++
 rtl/sd_blk_rr_arb.sv | 34 +++
 rtl/sd_blk_server.sv | 167 ++++++++++++++++
 tb/tb_sd_blk_server.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_blk_pkg.sv
// Shared types and constants for the SD block server.
package sd_blk_pkg;

  localparam int unsigned BLK_BYTES = 512;
  localparam int unsigned MAX_XFER  = 16384;
  localparam int unsigned BC_W      = 14;

  typedef enum logic [2:0] {
    StIdle,
    StAck,
    StRdMem,
    StRdPut,
    StWrGet,
    StWrMem,
    StDone
  } sd_srv_state_t;

  // Index of the last byte of a (cnt+1)-block transfer; the byte counter is
  // BC_W bits wide, so counts above 31 blocks wrap.
  function automatic logic [BC_W-1:0] last_bc(input logic [5:0] cnt);
    return BC_W'({cnt, 9'h1ff});
  endfunction

endpackage

// File: rtl/sd_blk_rr_arb.sv
// Two-way round-robin arbiter. The pointer moves past the granted channel on
// every advance pulse, so a lone requester also hands priority to the other.
module sd_blk_rr_arb (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt,
  output logic       idx
);

  logic ptr_q;

  // Pick the pointed-to channel on contention, otherwise the lone requester.
  always_comb begin
    idx = 1'b0;
    if (req[0] && (!req[1] || !ptr_q)) begin
      idx = 1'b0;
    end else if (req[1]) begin
      idx = 1'b1;
    end
    gnt = (|req) ? (2'b01 << idx) : 2'b00;
  end

  // Priority pointer flips to the channel that was not just granted.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_q <= 1'b0;
    end else if (adv) begin
      ptr_q <= ~idx;
    end
  end

endmodule

// File: rtl/sd_blk_server.sv
// Responder end of the MiSTer SD block interface, backed by a byte-wide
// memory port. Optional write protect input enabled by SD_BLK_WP_EN.
module sd_blk_server
  import sd_blk_pkg::*;
#(
  parameter int unsigned MEM_AW   = 24,
  parameter logic [31:0] CAP_BLKS = 32'd2880
) (
  input  logic              CLK,
  input  logic              RESET_N,
`ifdef SD_BLK_WP_EN
  input  logic [1:0]        wp,
`endif
  input  logic [31:0]       sd_lba       [2],
  input  logic [5:0]        sd_blk_cnt   [2],
  input  logic [1:0]        sd_rd,
  input  logic [1:0]        sd_wr,
  output logic [1:0]        sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din  [2],
  output logic              sd_buff_wr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  sd_srv_state_t   state_q;
  logic            ch_q;
  logic            op_rd_q;
  logic [31:0]     lba_q;
  logic [5:0]      cnt_q;
  logic [BC_W-1:0] bc_q;
  logic            wg_q;

  logic [1:0]      req;
  logic [1:0]      arb_gnt;
  logic            arb_idx;
  logic            arb_adv;
  logic [BC_W-1:0] bc_inc;
  logic [32:0]     blk_cur;
  logic [32:0]     blk_next;
  logic            oor_cur;
  logic            oor_next;
  logic            wp_ch;

  assign req     = sd_rd | sd_wr;
  assign arb_adv = (state_q == StIdle) && (|req);

  sd_blk_rr_arb u_arb (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .req     (req),
    .adv     (arb_adv),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  // Block index for the current and the following byte; 33 bits so a huge
  // LBA cannot wrap back into range.
  always_comb begin
    bc_inc   = bc_q + BC_W'(1);
    blk_cur  = {1'b0, lba_q} + 33'(bc_q[13:9]);
    blk_next = {1'b0, lba_q} + 33'(bc_inc[13:9]);
    oor_cur  = blk_cur >= {1'b0, CAP_BLKS};
    oor_next = blk_next >= {1'b0, CAP_BLKS};
  end

`ifdef SD_BLK_WP_EN
  assign wp_ch = wp[ch_q];
`else
  assign wp_ch = 1'b0;
`endif

  assign mem_addr     = MEM_AW'({blk_cur[31:0], bc_q[8:0]});
  assign sd_buff_addr = bc_q[8:0];

  // Transfer sequencer with registered handshake outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      ch_q         <= 1'b0;
      op_rd_q      <= 1'b0;
      lba_q        <= '0;
      cnt_q        <= '0;
      bc_q         <= '0;
      wg_q         <= 1'b0;
      sd_ack       <= '0;
      sd_buff_dout <= '0;
      sd_buff_wr   <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_wdata    <= '0;
    end else begin
      sd_buff_wr <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|req) begin
            ch_q    <= arb_idx;
            // Read wins when a channel raises both rd and wr.
            op_rd_q <= |(sd_rd & arb_gnt);
            lba_q   <= sd_lba[arb_idx];
            cnt_q   <= sd_blk_cnt[arb_idx];
            // Cleared at grant so the range check is valid during ACK.
            bc_q    <= '0;
            wg_q    <= 1'b0;
            state_q <= StAck;
          end
        end
        StAck: begin
          sd_ack[ch_q] <= 1'b1;
          if (op_rd_q) begin
            mem_rd  <= !oor_cur;
            state_q <= StRdMem;
          end else begin
            state_q <= StWrGet;
          end
        end
        StRdMem: begin
          // mem_rd low here means the block is out of range: return zeros.
          if (!mem_rd || mem_ready) begin
            sd_buff_dout <= mem_rd ? mem_rdata : 8'h00;
            mem_rd       <= 1'b0;
            sd_buff_wr   <= 1'b1;
            state_q      <= StRdPut;
          end
        end
        StRdPut: begin
          bc_q <= bc_inc;
          if (bc_q == last_bc(cnt_q)) begin
            state_q <= StDone;
          end else begin
            mem_rd  <= !oor_next;
            state_q <= StRdMem;
          end
        end
        StWrGet: begin
          // First cycle presents the address, second captures buffer data.
          if (!wg_q) begin
            wg_q <= 1'b1;
          end else begin
            wg_q      <= 1'b0;
            mem_wdata <= sd_buff_din[ch_q];
            mem_wr    <= !oor_cur && !wp_ch;
            state_q   <= StWrMem;
          end
        end
        StWrMem: begin
          if (!mem_wr || mem_ready) begin
            mem_wr  <= 1'b0;
            bc_q    <= bc_inc;
            state_q <= (bc_q == last_bc(cnt_q)) ? StDone : StWrGet;
          end
        end
        StDone: begin
          sd_ack  <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_blk_server.sv
// Self-checking bench for sd_blk_server: directed scenarios plus randomized
// transfers against a byte-level reference model.
module tb_sd_blk_server;

  localparam logic [31:0] CAP = 32'd2880;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] sd_lba     [2];
  logic [5:0]  sd_blk_cnt [2];
  logic [1:0]  sd_rd, sd_wr, sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din [2];
  logic        sd_buff_wr;
  logic [23:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ready;
`ifdef SD_BLK_WP_EN
  logic [1:0]  wp;
`endif

  sd_blk_server #(.MEM_AW(24), .CAP_BLKS(CAP)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
`ifdef SD_BLK_WP_EN
    .wp           (wp),
`endif
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_din  (sd_buff_din),
    .sd_buff_wr   (sd_buff_wr),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing store: untouched bytes follow a fixed pattern, written ones persist.
  logic [7:0] mem [int];

  function automatic logic [7:0] mem_get(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'(a) ^ 8'(a >> 12);
  endfunction

  function automatic logic [7:0] buf_pat(input int c, input int a);
    return (c == 1) ? (8'ha5 ^ 8'(a)) : (8'h5a ^ 8'(a));
  endfunction

  function automatic logic [31:0] hmix(input logic [31:0] h, input logic [31:0] v);
    return (h * 32'd33) ^ v;
  endfunction

  bit   hold = 1'b0;
  bit   rnd_stall = 1'b0;
  logic ok_q = 1'b1;
  assign mem_ready = (mem_rd | mem_wr) && !hold && ok_q;

  always @(posedge CLK) begin
    ok_q <= rnd_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int c = 0; c < 2; c++) sd_buff_din[c] <= buf_pat(c, int'(sd_buff_addr));
  end

  int          n_str, n_mw, n_oor_rd;
  logic [31:0] h_str, h_mw;

  // Memory port responder and observation of both data streams.
  always @(negedge CLK) begin
    mem_rdata = mem_get(int'(mem_addr));
    if (sd_buff_wr) begin
      n_str++;
      h_str = hmix(h_str, 32'({sd_buff_addr, sd_buff_dout}));
    end
    if (mem_wr && mem_ready) begin
      n_mw++;
      h_mw = hmix(h_mw, {mem_addr, mem_wdata});
      mem[int'(mem_addr)] = mem_wdata;
    end
    if (mem_rd && (32'(mem_addr >> 9) >= CAP)) n_oor_rd++;
  end

  task automatic clear_obs();
    n_str = 0; n_mw = 0; n_oor_rd = 0; h_str = 0; h_mw = 0;
  endtask

  task automatic wait_ack(input int ch, input logic val, input int budget, output int cyc);
    cyc = 0;
    while (sd_ack[ch] !== val && cyc < budget) begin
      @(negedge CLK);
      cyc++;
    end
    if (sd_ack[ch] !== val) check("ack_timeout", 64'(sd_ack[ch]), 64'(val));
  endtask

  // One whole transfer, checked against the byte-level model.
  task automatic run_xfer(input int ch, input bit rd, input logic [31:0] lba,
                          input logic [5:0] cnt, input bit wpen, input int stall_byte,
                          output int lat, output logic [23:0] addr0);
    int          e_str, e_mw, cyc, nb;
    logic [31:0] eh_str, eh_mw;
    longint      blk;
    int          off, a;
    bit          inr;
    e_str = 0; e_mw = 0; eh_str = 0; eh_mw = 0;
    nb = (int'(cnt) + 1) * 512;
    for (int k = 0; k < nb; k++) begin
      blk = longint'(lba) + longint'(k / 512);
      off = k % 512;
      a   = int'((blk * 512 + off) & 64'hff_ffff);
      inr = blk < longint'(CAP);
      if (rd) begin
        e_str++;
        eh_str = hmix(eh_str, 32'({9'(off), inr ? mem_get(a) : 8'h00}));
      end else if (inr && !wpen) begin
        e_mw++;
        eh_mw = hmix(eh_mw, {24'(a), buf_pat(ch, off)});
      end
    end
    @(negedge CLK);
    clear_obs();
    sd_lba[ch] = lba;
    sd_blk_cnt[ch] = cnt;
    if (rd) sd_rd[ch] = 1'b1; else sd_wr[ch] = 1'b1;
    wait_ack(ch, 1'b1, 20, lat);
    addr0 = mem_addr;
    sd_rd[ch] = 1'b0;
    sd_wr[ch] = 1'b0;
    if (stall_byte >= 0) begin
      cyc = 0;
      while (!(mem_rd && sd_buff_addr == 9'(stall_byte)) && cyc < 5000) begin
        @(negedge CLK);
        cyc++;
      end
      hold = 1'b1;
      repeat (7) begin
        @(negedge CLK);
        check("stall_hold", {mem_rd, sd_buff_wr, sd_buff_addr}, {1'b1, 1'b0, 9'(stall_byte)});
      end
      hold = 1'b0;
    end
    wait_ack(ch, 1'b0, 40000, cyc);
    repeat (2) @(negedge CLK);
    check("strobe_cnt", n_str, e_str);
    check("strobe_hash", h_str, eh_str);
    check("memwr_cnt", n_mw, e_mw);
    check("memwr_hash", h_mw, eh_mw);
    check("oor_mem_rd", n_oor_rd, 0);
  endtask

  initial begin
    int          lat, cyc, ch;
    logic [23:0] a0;
    RESET_N = 1'b0;
    sd_rd = '0; sd_wr = '0;
    for (int c = 0; c < 2; c++) begin
      sd_lba[c] = '0; sd_blk_cnt[c] = '0;
    end
`ifdef SD_BLK_WP_EN
    wp = 2'b00;
`endif
    repeat (3) @(negedge CLK);
    check("reset_outs", {sd_ack, mem_rd, mem_wr, sd_buff_wr, sd_buff_addr, sd_buff_dout,
                         mem_addr, mem_wdata}, 64'd0);
    RESET_N = 1'b1;

    // Single-block read on ch0 from lba 3.
    run_xfer(0, 1'b1, 32'd3, 6'd0, 1'b0, -1, lat, a0);
    check("ack_latency", lat, 2);
    check("first_addr", a0, 24'h600);

    // Two-block write on ch1 to lba 5.
    run_xfer(1, 1'b0, 32'd5, 6'd1, 1'b0, -1, lat, a0);
    check("wr_first_addr", a0, 24'ha00);

    // Contention straight after reset.
    @(negedge CLK) RESET_N = 1'b0;
    @(negedge CLK) RESET_N = 1'b1;
    clear_obs();
    sd_lba[0] = 32'd10; sd_blk_cnt[0] = 6'd0;
    sd_lba[1] = 32'd20; sd_blk_cnt[1] = 6'd0;
    sd_rd[0] = 1'b1; sd_wr[1] = 1'b1;
    wait_ack(0, 1'b1, 10, cyc);
    check("arb_first", sd_ack, 2'b01);
    sd_rd[0] = 1'b0;
    wait_ack(0, 1'b0, 5000, cyc);
    wait_ack(1, 1'b1, 10, cyc);
    check("arb_gap", cyc, 2);
    sd_wr[1] = 1'b0;
    wait_ack(1, 1'b0, 10000, cyc);
    sd_rd[0] = 1'b1; sd_wr[1] = 1'b1;
    cyc = 0;
    while (sd_ack == 2'b00 && cyc < 10) begin
      @(negedge CLK);
      cyc++;
    end
    check("arb_rerequest", sd_ack, 2'b01);
    sd_rd[0] = 1'b0;
    wait_ack(0, 1'b0, 5000, cyc);
    wait_ack(1, 1'b1, 10, cyc);
    sd_wr[1] = 1'b0;
    wait_ack(1, 1'b0, 10000, cyc);
    repeat (2) @(negedge CLK);
    check("arb_strobes", n_str, 1024);
    check("arb_memwr", n_mw, 1024);

    // Read straddling the end of the disk.
    run_xfer(0, 1'b1, CAP - 32'd1, 6'd1, 1'b0, -1, lat, a0);

    // Memory stall in the middle of a block.
    run_xfer(1, 1'b1, 32'd50, 6'd0, 1'b0, 100, lat, a0);

    // Reset in the middle of a write, then a normal read.
    @(negedge CLK);
    sd_lba[0] = 32'd7; sd_blk_cnt[0] = 6'd0; sd_wr[0] = 1'b1;
    wait_ack(0, 1'b1, 20, cyc);
    sd_wr[0] = 1'b0;
    cyc = 0;
    while (!(mem_wr && sd_buff_addr == 9'd200) && cyc < 5000) begin
      @(negedge CLK);
      cyc++;
    end
    #1 RESET_N = 1'b0;
    #1;
    check("reset_mid_xfer", {sd_ack, mem_rd, mem_wr, sd_buff_wr, sd_buff_addr, sd_buff_dout,
                             mem_addr, mem_wdata}, 64'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    run_xfer(0, 1'b1, 32'd7, 6'd0, 1'b0, -1, lat, a0);
    check("post_reset_latency", lat, 2);

`ifdef SD_BLK_WP_EN
    wp = 2'b01;
    run_xfer(0, 1'b0, 32'd9, 6'd0, 1'b1, -1, lat, a0);
    wp = 2'b00;
`endif

    // Randomized transfers with random memory wait states.
    rnd_stall = 1'b1;
    repeat (6) begin
      ch = int'($urandom_range(0, 1));
      run_xfer(ch, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? (CAP - 32'($urandom_range(0, 1)))
                                            : 32'($urandom_range(0, 200)),
               6'($urandom_range(0, 1)), 1'b0, -1, lat, a0);
      check("rnd_latency", lat, 2);
    end
    rnd_stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
